// File: rtl/online_otf_converter.sv
// On-the-fly converter: borrow-save digits (MSD first) -> two's-complement word on a valid/ready port.
// Optional parallel digit-word load is enabled by defining ONLINE_PAR_IN_EN.
module online_otf_converter #(
   parameter int Stage = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_digit,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [Stage:0]    out_data
`ifdef ONLINE_PAR_IN_EN
   ,
   input  logic              par_valid,
   input  logic [2*Stage-1:0] par_word
`endif
);

   localparam int W  = Stage + 1;
   localparam int CW = $clog2(Stage + 1);
   localparam logic [CW-1:0] LAST = CW'(Stage);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          state_r, nxt_state_s;
   logic [W-1:0]    q_r, nxt_q_s;
   // QM's top bit is shifted out before it can ever reach Q, so only W-1 bits are kept.
   logic [W-2:0]    qm_r, nxt_qm_s;
   logic [CW-1:0]   cnt_r, nxt_cnt_s, cnt_inc_s;
   logic            out_valid_r, nxt_out_valid_s;
   logic [W-1:0]    out_data_r, nxt_out_data_s;
   logic            in_ready_r, nxt_in_ready_s;
   logic            dig_en_s;
   logic [1:0]      dig_s, par_digit_s;
   logic            par_take_s, shifting_s, nxt_shifting_s;
   logic [2*W-2:0]  step_s;

   // One on-the-fly step: returns {next Q, next QM (low W-1 bits)}.
   function automatic logic [2*W-2:0] otf_step(input logic [W-2:0] q_lo,
                                                input logic [W-2:0] qm_lo,
                                                input logic [1:0]   d);
      case (d)
         2'b10:   otf_step = {q_lo,  1'b1, q_lo[W-3:0],  1'b0};
         2'b01:   otf_step = {qm_lo, 1'b1, qm_lo[W-3:0], 1'b0};
         default: otf_step = {q_lo,  1'b0, qm_lo[W-3:0], 1'b1};
      endcase
   endfunction

`ifdef ONLINE_PAR_IN_EN
   logic [2*Stage-1:0] shreg_r, nxt_shreg_s;
   logic               shifting_r;

   assign par_take_s  = par_valid && (state_r == IDLE) && !shifting_r;
   assign shifting_s  = shifting_r;
   assign par_digit_s = shreg_r[2*Stage-1 -: 2];

   // Parallel-word shift register next state.
   always_comb begin
      nxt_shreg_s    = shreg_r;
      nxt_shifting_s = shifting_r;
      if (par_take_s) begin
         nxt_shreg_s    = par_word;
         nxt_shifting_s = 1'b1;
      end else if (shifting_r) begin
         nxt_shreg_s    = {shreg_r[2*Stage-3:0], 2'b00};
         nxt_shifting_s = (cnt_inc_s != LAST);
      end else begin
         nxt_shreg_s    = shreg_r;
         nxt_shifting_s = 1'b0;
      end
   end

   // Parallel-word shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_r    <= '0;
         shifting_r <= 1'b0;
      end else begin
         shreg_r    <= nxt_shreg_s;
         shifting_r <= nxt_shifting_s;
      end
   end
`else
   assign par_take_s     = 1'b0;
   assign shifting_s     = 1'b0;
   assign nxt_shifting_s = 1'b0;
   assign par_digit_s    = 2'b00;
`endif

   assign cnt_inc_s = cnt_r + CW'(1);
   assign step_s    = otf_step(q_r[W-2:0], qm_r, dig_s);

   // Digit selection, Q/QM conversion and word-level state next state.
   always_comb begin
      nxt_state_s     = state_r;
      nxt_q_s         = q_r;
      nxt_qm_s        = qm_r;
      nxt_cnt_s       = cnt_r;
      nxt_out_valid_s = out_valid_r;
      nxt_out_data_s  = out_data_r;
      dig_en_s        = 1'b0;
      dig_s           = in_digit;

      if (shifting_s) begin
         dig_en_s = 1'b1;
         dig_s    = par_digit_s;
      end else if (in_valid && in_ready_r && !par_take_s) begin
         dig_en_s = 1'b1;
         dig_s    = in_digit;
      end else begin
         dig_en_s = 1'b0;
         dig_s    = in_digit;
      end

      case (state_r)
         IDLE, ACCUM: begin
            if (dig_en_s) begin
               nxt_q_s   = step_s[2*W-2 -: W];
               nxt_qm_s  = step_s[W-2:0];
               nxt_cnt_s = cnt_inc_s;
               if (cnt_inc_s == LAST) begin
                  nxt_state_s     = HOLD;
                  nxt_out_valid_s = 1'b1;
                  nxt_out_data_s  = step_s[2*W-2 -: W];
               end else begin
                  nxt_state_s = ACCUM;
               end
            end else begin
               nxt_state_s = state_r;
            end
         end
         HOLD: begin
            // Re-seed Q/QM on the way back to IDLE so the next word starts clean.
            if (out_ready) begin
               nxt_state_s     = IDLE;
               nxt_out_valid_s = 1'b0;
               nxt_q_s         = '0;
               nxt_qm_s        = '1;
               nxt_cnt_s       = '0;
            end else begin
               nxt_state_s = HOLD;
            end
         end
         default: begin
            nxt_state_s     = IDLE;
            nxt_out_valid_s = 1'b0;
            nxt_q_s         = '0;
            nxt_qm_s        = '1;
            nxt_cnt_s       = '0;
         end
      endcase

      nxt_in_ready_s = (nxt_state_s != HOLD) && !nxt_shifting_s;
   end

   // Converter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         q_r         <= '0;
         qm_r        <= '1;
         cnt_r       <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= nxt_state_s;
         q_r         <= nxt_q_s;
         qm_r        <= nxt_qm_s;
         cnt_r       <= nxt_cnt_s;
         out_valid_r <= nxt_out_valid_s;
         out_data_r  <= nxt_out_data_s;
         in_ready_r  <= nxt_in_ready_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;

endmodule
